// File: rtl/tone_pkg.sv
// Shared types for the tone sequencer: FSM states, queued note record and
// the frequency ceiling applied when a note is loaded.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    localparam logic [31:0] FREQ_MAX = 32'd999999;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] dur_ms;
    } note_t;

    localparam int NOTE_W = $bits(note_t);

    function automatic logic [31:0] sat_freq(input logic [31:0] f);
        return (f > FREQ_MAX) ? FREQ_MAX : f;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Note queue: DEPTH entries of one packed note, head visible on o_data,
// synchronous reset and flush clear the pointers only.
module note_fifo
    import tone_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [NOTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [NOTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [NOTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: the storage array is deliberately not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued notes one at a time: each note drives freq_out/tone_en for
// its duration in ms, followed by an optional silent gap.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_HZ     = 125000000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MS     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [31:0] note_freq,
    input  logic [15:0] note_dur_ms,
    input  logic        abort,
    output logic [31:0] freq_out,
    output logic        tone_en,
    output logic        busy,
    output logic        note_done
);

    localparam int          TICK         = CLK_HZ / 1000;
    localparam int          PW           = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK - 1);
    localparam logic [15:0] GAP_LEN      = 16'(GAP_MS);
    localparam logic        ONE_CYCLE_MS = (TICK == 1);

    state_t            r_state;
    note_t             r_note;
    logic [15:0]       r_ms_cnt;
    logic [PW-1:0]     r_presc;
    logic [31:0]       r_freq;
    logic              r_tone_en;
    logic              r_note_done;

    logic [NOTE_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_tick;
    logic              w_last;
    logic              w_playing;
    logic [31:0]       w_sat;

    assign note_ready = ~w_full & ~rst;
    assign w_push     = note_valid & note_ready & ~abort;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty & ~abort & ~rst;
    assign w_tick     = (r_presc == '0);
    assign w_last     = w_tick & (r_ms_cnt == 16'd1);
    assign w_playing  = (r_state == ST_PLAY);
    assign w_sat      = sat_freq(r_note.freq);

    assign freq_out  = r_freq;
    assign tone_en   = r_tone_en;
    assign note_done = r_note_done;
    assign busy      = (r_state != ST_IDLE) | ~w_empty;

    note_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_note_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_push  (w_push),
        .i_data  ({note_freq, note_dur_ms}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // note_done is registered, so it is raised one cycle early: on the cycle before the final prescaler tick.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state     <= ST_IDLE;
            r_note      <= '0;
            r_ms_cnt    <= '0;
            r_presc     <= '0;
            r_freq      <= '0;
            r_tone_en   <= 1'b0;
            r_note_done <= 1'b0;
        end else begin
            r_note_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_note  <= w_head;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_freq   <= w_sat;
                    r_ms_cnt <= r_note.dur_ms;
                    r_presc  <= PRESC_MAX;
                    if (r_note.dur_ms == 16'd0) begin
                        r_state     <= ST_IDLE;
                        r_note_done <= 1'b1;
                    end else begin
                        r_state     <= ST_PLAY;
                        r_tone_en   <= (w_sat != 32'd0);
                        r_note_done <= ONE_CYCLE_MS && (r_note.dur_ms == 16'd1);
                    end
                end
                default: begin
                    if (w_last) begin
                        r_tone_en <= 1'b0;
                        if (w_playing && (GAP_MS != 0)) begin
                            r_state  <= ST_GAP;
                            r_ms_cnt <= GAP_LEN;
                            r_presc  <= PRESC_MAX;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_ms_cnt <= '0;
                        end
                    end else if (w_tick) begin
                        r_presc     <= PRESC_MAX;
                        r_ms_cnt    <= r_ms_cnt - 16'd1;
                        r_note_done <= w_playing && ONE_CYCLE_MS && (r_ms_cnt == 16'd2);
                    end else begin
                        r_presc     <= r_presc - 1'b1;
                        r_note_done <= w_playing && (r_ms_cnt == 16'd1) && (r_presc == PW'(1));
                    end
                end
            endcase
        end
    end

endmodule
